// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared types, limits and byte-merge helper for the register bank controller
package reg_bank_pkg;

    parameter int RB_DATA_WIDTH = 32;
    localparam int MAX_RD_LATENCY = 4;

    typedef struct packed {
        logic                     valid;
        logic                     err;
        logic [RB_DATA_WIDTH-1:0] data;
    } rd_pipe_t;

    // Bytes whose strobe is set take new_w, all other bytes keep old_w
    function automatic logic [RB_DATA_WIDTH-1:0] strb_merge(
        input logic [RB_DATA_WIDTH-1:0]   old_w,
        input logic [RB_DATA_WIDTH-1:0]   new_w,
        input logic [RB_DATA_WIDTH/8-1:0] strb
    );
        logic [RB_DATA_WIDTH-1:0] res;
        for (int b = 0; b < RB_DATA_WIDTH / 8; b++)
            res[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/reg_bank_rd_pipe.sv
// reg_bank_rd_pipe: fixed-latency read return pipeline with synchronous flush
module reg_bank_rd_pipe
    import reg_bank_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  rd_pipe_t              push_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    rd_pipe_t pipe_q [RD_LATENCY];

    // Shift the read snapshot towards the output; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < RD_LATENCY; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= push_i;
            for (int k = 1; k < RD_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign rvalid_o = pipe_q[RD_LATENCY-1].valid;
    assign rdata_o  = pipe_q[RD_LATENCY-1].valid ? DATA_WIDTH'(pipe_q[RD_LATENCY-1].data) : '0;
    assign err_o    = pipe_q[RD_LATENCY-1].valid && pipe_q[RD_LATENCY-1].err;

endmodule

// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: register bank with byte-strobed bus writes, latency-configurable reads and a hardware update port
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sel_i,
    input  logic                    wr_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    rvalid_o,
    output logic                    ready_o,
    output logic                    err_o,
    input  logic                    hw_we_i,
    input  logic [ADDR_WIDTH-1:0]   hw_addr_i,
    input  logic [DATA_WIDTH-1:0]   hw_wdata_i
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(MAX_RD_LATENCY);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  werr_q, werr_d;
    logic                  acc, rd_acc, in_range, rd_err;
    rd_pipe_t              rd_push;

    assign ready_o  = state_q == IDLE;
    assign acc      = sel_i && ready_o;
    assign rd_acc   = acc && !wr_i;
    assign in_range = 32'(addr_i) < DEPTH;
    assign werr_d   = acc && wr_i && !in_range;

    // Read snapshot taken from pre-edge contents; out-of-range reads return zero with err
    always_comb begin
        rd_push       = '0;
        rd_push.valid = rd_acc;
        rd_push.err   = rd_acc && !in_range;
        rd_push.data  = (rd_acc && in_range) ? RB_DATA_WIDTH'(mem_q[addr_i[IDX_W-1:0]]) : '0;
    end

    // Next register contents: hardware word first, bus strobed bytes override it on collision
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (hw_we_i && hw_addr_i == ADDR_WIDTH'(i)) mem_d[i] = hw_wdata_i;
            if (acc && wr_i && addr_i == ADDR_WIDTH'(i))
                mem_d[i] = DATA_WIDTH'(strb_merge(RB_DATA_WIDTH'(mem_d[i]), RB_DATA_WIDTH'(wdata_i),
                                                  (RB_DATA_WIDTH/8)'(wstrb_i)));
        end
    end

    // Ready FSM: hold off the bus for RD_LATENCY cycles after a read is accepted
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (rd_acc) begin
                state_d = RD_WAIT;
                cnt_d   = CNT_W'(RD_LATENCY - 1);
            end
        end else if (cnt_q == '0) begin
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State, storage and write-error pulse registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            werr_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            werr_q  <= werr_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    reg_bank_rd_pipe #(
        .RD_LATENCY(RD_LATENCY),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rd_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (rd_push),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o),
        .err_o   (rd_err)
    );

    assign err_o = werr_q || rd_err;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// tb_reg_bank_ctrl: directed vector and corner-sequence checks of reg_bank_ctrl at read latencies 1, 2 and 3
module tb_reg_bank_ctrl;

    typedef struct {
        logic        sel;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        hw_we;
        logic [7:0]  hw_addr;
        logic [31:0] hw_wdata;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic        e_ready;
        logic        e_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sel, wr, hw_we;
    logic [7:0]  addr, hw_addr;
    logic [31:0] wdata, hw_wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata_l  [1:3];
    logic        rvalid_l [1:3];
    logic        ready_l  [1:3];
    logic        err_l    [1:3];
    int          n_cmp = 0;
    int          n_err = 0;
    vec_t        vq[$];

    always #5 clk = ~clk;

    reg_bank_ctrl #(.RD_LATENCY(1)) u_l1 (
        .clk(clk), .rstn(rstn), .sel_i(sel), .wr_i(wr), .addr_i(addr), .wdata_i(wdata),
        .wstrb_i(wstrb), .rdata_o(rdata_l[1]), .rvalid_o(rvalid_l[1]), .ready_o(ready_l[1]),
        .err_o(err_l[1]), .hw_we_i(hw_we), .hw_addr_i(hw_addr), .hw_wdata_i(hw_wdata)
    );

    reg_bank_ctrl #(.RD_LATENCY(2)) u_l2 (
        .clk(clk), .rstn(rstn), .sel_i(sel), .wr_i(wr), .addr_i(addr), .wdata_i(wdata),
        .wstrb_i(wstrb), .rdata_o(rdata_l[2]), .rvalid_o(rvalid_l[2]), .ready_o(ready_l[2]),
        .err_o(err_l[2]), .hw_we_i(hw_we), .hw_addr_i(hw_addr), .hw_wdata_i(hw_wdata)
    );

    reg_bank_ctrl #(.RD_LATENCY(3)) u_l3 (
        .clk(clk), .rstn(rstn), .sel_i(sel), .wr_i(wr), .addr_i(addr), .wdata_i(wdata),
        .wstrb_i(wstrb), .rdata_o(rdata_l[3]), .rvalid_o(rvalid_l[3]), .ready_o(ready_l[3]),
        .err_o(err_l[3]), .hw_we_i(hw_we), .hw_addr_i(hw_addr), .hw_wdata_i(hw_wdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int l, input logic e_rv, input logic [31:0] e_rd,
                           input logic e_rdy, input logic e_er);
        chk({nm, "_rvalid"}, 32'(rvalid_l[l]), 32'(e_rv));
        chk({nm, "_rdata"},  rdata_l[l],       e_rd);
        chk({nm, "_ready"},  32'(ready_l[l]),  32'(e_rdy));
        chk({nm, "_err"},    32'(err_l[l]),    32'(e_er));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sel = 0; wr = 0; addr = '0; wdata = '0; wstrb = '0;
        hw_we = 0; hw_addr = '0; hw_wdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rstn = 0;
        repeat (2) step();
        rstn = 1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        sel = 1; wr = 1; addr = a; wdata = d; wstrb = 4'hF;
        step();
        idle();
    endtask

    function automatic logic [31:0] exp_mem(input int a);
        return a == 3 ? 32'h5555_5555 : a == 10 ? 32'h1234_FFFF : 32'h0;
    endfunction

    initial begin
        //         sel wr  addr   wdata          strb  hw  hw_addr hw_wdata      rv  rdata         rdy err
        vq.push_back('{1, 0, 8'h05, 32'h0,         4'h0, 0, 8'h00, 32'h0,         1, 32'h0,         0, 0});
        vq.push_back('{0, 0, 8'h00, 32'h0,         4'h0, 0, 8'h00, 32'h0,         0, 32'h0,         1, 0});
        vq.push_back('{1, 1, 8'h03, 32'hAABBCCDD,  4'hF, 0, 8'h00, 32'h0,         0, 32'h0,         1, 0});
        vq.push_back('{1, 1, 8'h03, 32'h11223344,  4'h5, 0, 8'h00, 32'h0,         0, 32'h0,         1, 0});
        vq.push_back('{1, 0, 8'h03, 32'h0,         4'h0, 0, 8'h00, 32'h0,         1, 32'hAA22CC44,  0, 0});
        vq.push_back('{0, 0, 8'h00, 32'h0,         4'h0, 0, 8'h00, 32'h0,         0, 32'h0,         1, 0});
        vq.push_back('{1, 1, 8'h40, 32'hDEADBEEF,  4'hF, 0, 8'h00, 32'h0,         0, 32'h0,         1, 1});
        vq.push_back('{1, 0, 8'h7F, 32'h0,         4'h0, 0, 8'h00, 32'h0,         1, 32'h0,         0, 1});
        vq.push_back('{0, 0, 8'h00, 32'h0,         4'h0, 0, 8'h00, 32'h0,         0, 32'h0,         1, 0});
        vq.push_back('{1, 0, 8'h00, 32'h0,         4'h0, 0, 8'h00, 32'h0,         1, 32'h0,         0, 0});
        vq.push_back('{0, 0, 8'h00, 32'h0,         4'h0, 0, 8'h00, 32'h0,         0, 32'h0,         1, 0});
        vq.push_back('{1, 1, 8'h0A, 32'h0000FFFF,  4'h3, 1, 8'h0A, 32'h12345678,  0, 32'h0,         1, 0});
        vq.push_back('{1, 0, 8'h0A, 32'h0,         4'h0, 0, 8'h00, 32'h0,         1, 32'h1234FFFF,  0, 0});
        vq.push_back('{0, 0, 8'h00, 32'h0,         4'h0, 0, 8'h00, 32'h0,         0, 32'h0,         1, 0});
        vq.push_back('{1, 0, 8'h03, 32'h0,         4'h0, 1, 8'h03, 32'h55555555,  1, 32'hAA22CC44,  0, 0});
        vq.push_back('{1, 1, 8'h03, 32'hFFFFFFFF,  4'hF, 0, 8'h00, 32'h0,         0, 32'h0,         1, 0});
        vq.push_back('{1, 0, 8'h03, 32'h0,         4'h0, 0, 8'h00, 32'h0,         1, 32'h55555555,  0, 0});
        vq.push_back('{0, 0, 8'h00, 32'h0,         4'h0, 0, 8'h00, 32'h0,         0, 32'h0,         1, 0});
        vq.push_back('{0, 0, 8'h00, 32'h0,         4'h0, 1, 8'h50, 32'h00000099,  0, 32'h0,         1, 0});
        vq.push_back('{1, 1, 8'h04, 32'hFFFFFFFF,  4'h0, 0, 8'h00, 32'h0,         0, 32'h0,         1, 0});
        vq.push_back('{1, 0, 8'h04, 32'h0,         4'h0, 0, 8'h00, 32'h0,         1, 32'h0,         0, 0});
        vq.push_back('{0, 0, 8'h00, 32'h0,         4'h0, 0, 8'h00, 32'h0,         0, 32'h0,         1, 0});

        do_reset();
        chk_all("reset_l1", 1, 0, 32'h0, 1, 0);

        foreach (vq[i]) begin
            sel = vq[i].sel; wr = vq[i].wr; addr = vq[i].addr; wdata = vq[i].wdata;
            wstrb = vq[i].wstrb; hw_we = vq[i].hw_we; hw_addr = vq[i].hw_addr; hw_wdata = vq[i].hw_wdata;
            step();
            chk_all($sformatf("vec%0d", i), 1, vq[i].e_rvalid, vq[i].e_rdata, vq[i].e_ready, vq[i].e_err);
        end
        idle();

        for (int a = 0; a < 64; a++) begin
            sel = 1; wr = 0; addr = 8'(a);
            step();
            idle();
            chk($sformatf("sweep_%0d", a), rdata_l[1], exp_mem(a));
            step();
        end

        do_reset();
        bus_write(8'h07, 32'hCAFEF00D);
        sel = 1; wr = 0; addr = 8'h07;
        step();
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("lat3_c%0d_ready", k), 32'(ready_l[3]), 32'(k == 4));
            chk($sformatf("lat3_c%0d_rvalid", k), 32'(rvalid_l[3]), 32'(k == 3));
            chk($sformatf("lat3_c%0d_rdata", k), rdata_l[3], k == 3 ? 32'hCAFEF00D : 32'h0);
            step();
        end
        idle();
        repeat (5) step();

        do_reset();
        bus_write(8'h01, 32'h12345678);
        sel = 1; wr = 0; addr = 8'h01;
        step();
        idle();
        chk_all("lat2_c1", 2, 0, 32'h0, 0, 0);
        rstn = 0;
        step();
        rstn = 1;
        chk_all("lat2_rst", 2, 0, 32'h0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("lat2_norv_%0d", k), 32'(rvalid_l[2]), 32'h0);
        end
        sel = 1; wr = 0; addr = 8'h01;
        step();
        idle();
        chk_all("lat2_rd_c1", 2, 0, 32'h0, 0, 0);
        step();
        chk_all("lat2_rd_c2", 2, 1, 32'h0, 0, 0);
        step();
        chk_all("lat2_rd_c3", 2, 0, 32'h0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_bank_ctrl.md
Name: reg_bank_ctrl

Overview:
- Parametrised register bank controller with a sel/wr/ready bus protocol. Successor to the single-width 16-bit register controller.
- Adds byte-strobed writes, configurable read latency with an rvalid strobe, out-of-range error reporting, and a hardware update port for status registers.
- Sits between the bus decode and block-level configuration/status logic.

Parameters:
- ADDR_WIDTH, 8, bus address width.
- DATA_WIDTH, 32, register width; must be a multiple of 8.
- DEPTH, 64, number of implemented registers; must be <= 2**ADDR_WIDTH.
- RD_LATENCY, 1, cycles from read acceptance to rvalid; legal range 1..4.
- RESET_VAL, 32'h0000_0000, reset value of every register (DATA_WIDTH bits).

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- sel  in  1  bus request
- wr  in  1  1=write, 0=read
- addr  in  ADDR_WIDTH  register address
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte write enables
- rdata  out  DATA_WIDTH  read data; valid only while rvalid=1
- rvalid  out  1  read data strobe, one cycle
- ready  out  1  1 = bus may issue a request
- err  out  1  error strobe, one cycle
- hw_we  in  1  hardware update enable
- hw_addr  in  ADDR_WIDTH  hardware update address
- hw_wdata  in  DATA_WIDTH  hardware update data (full word)

Behaviour:
- Reset (rstn=0 at a clk edge):
  - all registers <= RESET_VAL; ready=1, rdata=0, rvalid=0, err=0.
  - read pipeline flushed; any in-flight read is discarded and no rvalid follows.
- Acceptance: a request is accepted at an edge where sel=1 and ready=1. While ready=0, sel/wr/addr are ignored.
- Write, in range (addr < DEPTH):
  - at the accepting edge, each byte b with wstrb[b]=1 takes wdata byte b; other bytes hold.
  - ready stays 1, so back-to-back writes run at one per cycle. No rvalid.
  - wstrb=0 is a legal no-op write; err=0.
- Write, out of range (addr >= DEPTH): no state change; err=1 for exactly the cycle after acceptance.
- Read, accepted in cycle 0:
  - data is the register value before that edge's updates (read-before-write).
  - ready=0 in cycles 1..RD_LATENCY; ready=1 again in cycle RD_LATENCY+1.
  - rvalid=1 and rdata=snapshot in cycle RD_LATENCY only; rdata=0 whenever rvalid=0.
  - out-of-range read: rdata=0 and err=1, coincident with rvalid.
- Hardware port:
  - hw_we=1 with hw_addr < DEPTH writes the full word at the edge, independent of ready.
  - hw_we with hw_addr >= DEPTH is ignored silently (no err).
- Collision (bus write and hw_we to the same address at the same edge): bytes with wstrb=1 take bus data, the remaining bytes take hw_wdata.
- A read accepted at the same edge as hw_we to the same address returns the pre-edge value.
- Only one read is outstanding at a time; the ready gating guarantees this.
- err is never asserted for in-range accesses.

Decomposition:
- Package reg_bank_pkg holds:
  - localparam MAX_RD_LATENCY=4;
  - typedef rd_pipe_t {logic valid; logic err; logic [DATA_WIDTH-1:0] data}, parametrised via a package parameter default of 32;
  - function strb_merge(old, new, strb) returning the byte-merged word.
- One sub-module, reg_bank_rd_pipe:
  - a RD_LATENCY-deep shift of rd_pipe_t;
  - outputs rvalid/rdata/err-for-reads;
  - synchronous flush on reset.
- Write-error pulse, ready FSM (IDLE / RD_WAIT with down-counter) and the storage array stay in reg_bank_ctrl.

Test Plan:
1. Reset, then read addr 0x05 with RD_LATENCY=1 -> cycle 1: rvalid=1, ready=0, rdata=RESET_VAL; cycle 2: ready=1, rdata=0.
2. Write 0xAABBCCDD to 0x03 with wstrb=4'b1111, then wstrb=4'b0101 with 0x11223344, then read -> rdata=0xAA22CC44.
3. RD_LATENCY=3: read accepted cycle 0 -> ready=0 cycles 1-3, rvalid/rdata in cycle 3 only; sel held high throughout -> no second acceptance before cycle 4.
4. DEPTH=64: write to 0x40 -> err=1 in cycle 1, no register changes (readback of 0x00..0x3F unchanged); read 0x7F -> rdata=0, err=1 with rvalid.
5. Same edge: bus write 0x0000FFFF wstrb=4'b0011 and hw_we=1 with hw_wdata=0x12345678 to 0x0A -> readback 0x1234FFFF.
6. Reset asserted in cycle 1 of a RD_LATENCY=2 read -> no rvalid ever appears; after release ready=1, all registers = RESET_VAL.
